// File: rtl/plru_pkg.sv
// Shared types and tree-indexing helpers for the per-set pseudo-LRU tracker.
// Tree nodes are stored in heap order: node 0 is the root, children of n are 2n+1 / 2n+2.
package plru_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } flush_state_e;

    function automatic int way_bits_f(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    // Heap index of the node visited at tree level lvl on the way to leaf way.
    function automatic int path_node(input int lvl, input int way, input int way_bits);
        return ((1 << lvl) - 1) + (way >> (way_bits - lvl));
    endfunction

    // Branch taken at level lvl toward way: 0 = left (lower ways), 1 = right.
    function automatic logic path_dir(input int lvl, input int way, input int way_bits);
        return 1'((way >> (way_bits - 1 - lvl)) & 1);
    endfunction

endpackage

// File: rtl/plru_victim_sel.sv
// Combinational victim choice for one set: lowest free unlocked way first,
// otherwise a tree walk that steers around fully locked subtrees.
module plru_victim_sel
    import plru_pkg::*;
#(
    parameter int WAYS     = 4,
    parameter int WAY_BITS = way_bits_f(WAYS)
) (
    input  logic [WAYS-2:0]     tree_i,
    input  logic [WAYS-1:0]     valid_mask_i,
    input  logic [WAYS-1:0]     lock_mask_i,
    output logic [WAY_BITS-1:0] victim_way_o,
    output logic                victim_valid_o
);

    localparam int NODES = WAYS - 1;

    logic                inv_hit;
    logic [WAY_BITS-1:0] inv_way;
    logic [WAY_BITS-1:0] walk_way;
    logic [WAYS-1:0]     span_mask;
    logic                left_locked;
    logic                right_locked;
    logic                dir;
    int                  node;
    int                  pfx;
    int                  span;

    always_comb begin
        inv_hit      = 1'b0;
        inv_way      = '0;
        walk_way     = '0;
        span_mask    = '0;
        left_locked  = 1'b0;
        right_locked = 1'b0;
        dir          = 1'b0;
        node         = 0;
        pfx          = 0;
        span         = 0;

        // Descending scan so the lowest-numbered free way wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_mask_i[w] && !lock_mask_i[w]) begin
                inv_hit = 1'b1;
                inv_way = WAY_BITS'(w);
            end
        end

        for (int l = 0; l < WAY_BITS; l++) begin
            span         = WAYS >> (l + 1);
            span_mask    = (WAYS'(1) << span) - WAYS'(1);
            left_locked  = ((lock_mask_i >> ((2 * pfx) * span)) & span_mask) == span_mask;
            right_locked = ((lock_mask_i >> ((2 * pfx + 1) * span)) & span_mask) == span_mask;
            dir          = |(tree_i & (NODES'(1) << node));
            if (!dir && left_locked) begin
                dir = 1'b1;
            end else if (dir && right_locked) begin
                dir = 1'b0;
            end
            pfx  = 2 * pfx + int'(dir);
            node = 2 * node + 1 + int'(dir);
        end
        walk_way = WAY_BITS'(pfx);

        if (&lock_mask_i) begin
            victim_way_o   = '0;
            victim_valid_o = 1'b0;
        end else if (inv_hit) begin
            victim_way_o   = inv_way;
            victim_valid_o = 1'b1;
        end else begin
            victim_way_o   = walk_way;
            victim_valid_o = 1'b1;
        end
    end

endmodule

// File: rtl/plru_tree_nway.sv
// Per-set tree pseudo-LRU tracker: tree storage, access/invalidate write ports,
// combinational victim read port and a one-set-per-cycle flush sweep.
module plru_tree_nway
    import plru_pkg::*;
#(
    parameter int SETS       = 256,
    parameter int INDEX_BITS = 8,
    parameter int WAYS       = 4,
    parameter int WAY_BITS   = way_bits_f(WAYS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [INDEX_BITS-1:0] rd_index,
    input  logic [WAYS-1:0]       rd_valid_mask,
    input  logic [WAYS-1:0]       rd_lock_mask,
    output logic [WAY_BITS-1:0]   victim_way,
    output logic                  victim_valid,
    input  logic                  upd_en,
    input  logic [INDEX_BITS-1:0] upd_index,
    input  logic [WAY_BITS-1:0]   upd_way,
    input  logic                  inv_en,
    input  logic [INDEX_BITS-1:0] inv_index,
    input  logic [WAY_BITS-1:0]   inv_way,
    input  logic                  flush_req,
    output logic                  busy,
    output logic                  flush_done
);

    localparam int NODES = WAYS - 1;

    logic [NODES-1:0]      tree_q [SETS];
    flush_state_e          state_q, state_d;
    logic [INDEX_BITS-1:0] cnt_q, cnt_d;

    logic [NODES-1:0]      rd_tree;
    logic [NODES-1:0]      upd_tree_d;
    logic [NODES-1:0]      inv_tree_d;
    logic [NODES-1:0]      upd_mask;
    logic [NODES-1:0]      inv_mask;
    logic                  upd_we;
    logic                  inv_we;
    logic                  flush_we;
    logic                  sel_valid;

    assign busy    = (state_q != IDLE);
    assign rd_tree = tree_q[rd_index];

    plru_victim_sel #(
        .WAYS     (WAYS),
        .WAY_BITS (WAY_BITS)
    ) u_victim_sel (
        .tree_i         (rd_tree),
        .valid_mask_i   (rd_valid_mask),
        .lock_mask_i    (rd_lock_mask),
        .victim_way_o   (victim_way),
        .victim_valid_o (sel_valid)
    );

    assign victim_valid = sel_valid & ~busy;

    // An invalidate to the same set takes precedence over a concurrent access.
    assign inv_we = inv_en & ~busy;
    assign upd_we = upd_en & ~busy & ~(inv_en && (inv_index == upd_index));

    // Access points every path node away from the way; invalidate points toward it.
    always_comb begin
        upd_tree_d = tree_q[upd_index];
        inv_tree_d = tree_q[inv_index];
        upd_mask   = '0;
        inv_mask   = '0;
        for (int l = 0; l < WAY_BITS; l++) begin
            upd_mask = NODES'(1) << path_node(l, int'(upd_way), WAY_BITS);
            inv_mask = NODES'(1) << path_node(l, int'(inv_way), WAY_BITS);
            if (path_dir(l, int'(upd_way), WAY_BITS)) begin
                upd_tree_d = upd_tree_d & ~upd_mask;
            end else begin
                upd_tree_d = upd_tree_d | upd_mask;
            end
            if (path_dir(l, int'(inv_way), WAY_BITS)) begin
                inv_tree_d = inv_tree_d | inv_mask;
            end else begin
                inv_tree_d = inv_tree_d & ~inv_mask;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        flush_we   = 1'b0;
        flush_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush_req) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end
            end
            FLUSH: begin
                flush_we = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == INDEX_BITS'(SETS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                flush_done = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                tree_q[s] <= '0;
            end
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (flush_we) begin
                tree_q[cnt_q] <= '0;
            end
            if (upd_we) begin
                tree_q[upd_index] <= upd_tree_d;
            end
            if (inv_we) begin
                tree_q[inv_index] <= inv_tree_d;
            end
        end
    end

endmodule

// File: doc/plru_tree_nway.md
# plru_tree_nway

Per-set tree pseudo-LRU replacement tracker for N-way set-associative caches; the parametrised successor of the 2-way LRU bit array. It holds WAYS-1 tree bits per set and selects a victim combinationally for the addressed set. Selection prefers invalid ways and skips locked ways. Access updates, invalidation hints and a sequenced whole-array flush update the tree state. It sits beside the tag/valid arrays in the L1 I/D cache controllers.

## Interface
Parameters:
- SETS, 256, number of sets (addressable entries)
- INDEX_BITS, 8, set index width; SETS == 2**INDEX_BITS
- WAYS, 4, associativity; power of 2, >= 2
- WAY_BITS, 2, log2(WAYS)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- rd_index  in  INDEX_BITS  set being looked up
- rd_valid_mask  in  WAYS  valid bits of that set, from the tag array
- rd_lock_mask  in  WAYS  ways excluded from replacement
- victim_way  out  WAY_BITS  selected victim
- victim_valid  out  1  victim_way is usable
- upd_en  in  1  access (hit or fill) to upd_way of upd_index
- upd_index  in  INDEX_BITS
- upd_way  in  WAY_BITS
- inv_en  in  1  way inv_way of inv_index invalidated; make it next victim
- inv_index  in  INDEX_BITS
- inv_way  in  WAY_BITS
- flush_req  in  1  single-cycle request to clear all tree state
- busy  out  1  flush in progress
- flush_done  out  1  one-cycle pulse at flush completion

## Operation
- Tree encoding: heap order; node 0 is root; children of node n are 2n+1 and 2n+2. Bit 0 selects the left subtree (lower way numbers); bit 1 selects the right subtree.
- Victim priority:
  - (1) Lowest-numbered way with valid=0 and lock=0.
  - (2) Otherwise walk the tree from the root. At each node, follow the bit unless every way under that child is locked; in that case take the sibling.
  - (3) If all ways are locked: victim_valid=0 and victim_way=0.
- Access update (upd_en): every node on upd_way's path is set to point away from upd_way.
- Invalidate (inv_en): every node on inv_way's path is set to point toward inv_way.
- upd_en and inv_en on the same cycle:
  - Different index: both apply.
  - Same index: inv applies; upd is dropped.
- WAYS=2: one bit per set, equal to ~last accessed way. This matches the legacy 2-way behaviour.
- FSM states:
  - IDLE: flush_req leads to FLUSH with the sweep counter at 0.
  - FLUSH: clears the tree bits of set[counter] each cycle and increments the counter. On counter == SETS-1, go to DONE.
  - DONE: flush_done=1 for one cycle, then IDLE.
- While busy:
  - upd_en and inv_en are ignored.
  - victim_valid=0.
  - flush_req is ignored.
- flush_req in DONE is ignored.

## Timing
- Reset values: all tree bits 0, FSM IDLE, counter 0, busy=0, flush_done=0. victim_valid=1 and victim_way=0 for any set with no locks.
- Reset mid-flush: immediate return to IDLE with all state cleared; no flush_done pulse.
- Victim path: combinational from rd_index, masks and stored state, in the same cycle.
- Updates: written on the clk edge. They are visible to a read of the same index in the next cycle.
- Same-cycle read of an index being updated returns the pre-update state (no bypass).
- Flush latency: busy rises the cycle after flush_req and stays high for SETS+1 cycles (FLUSH for SETS cycles, then DONE). flush_done is coincident with the last busy cycle.

## Structure
- Package plru_pkg:
  - clog2-based WAY_BITS helper
  - node-index/path helper functions: path node for a given level and way, and direction bit
  - FSM state enum {IDLE, FLUSH, DONE}
- Sub-module plru_victim_sel: combinational tree walk with valid/lock masks, parametrised on WAYS. It is instantiated once on the read port.
- Top level holds the tree storage, both write ports and the flush FSM.

## Test plan
All scenarios use WAYS=4.
- Reset, rd_index=5, valid=4'b1111, lock=0 -> victim_way=0, victim_valid=1, busy=0.
- upd way0 at set 5 -> next cycle victim_way=2. Then upd way2 at set 5 -> victim_way=1.
- Set 5, valid=4'b1011, tree pointing at way1 -> victim_way=2. With valid=4'b1111 -> victim_way=1.
- After reset, lock=4'b0011 -> victim_way=2. lock=4'b1111 -> victim_valid=0, victim_way=0.
- inv way3 at set 7, with same-cycle upd way1 at set 7 -> next cycle victim_way=3 (upd dropped). Same test with upd at set 8 -> both applied.
- SETS=16, several sets dirtied, flush_req pulse:
  - busy high for 17 cycles; flush_done on the 17th.
  - upd_en issued during busy has no effect.
  - afterwards every set gives victim_way=0.
  - Repeat with rst_n asserted at sweep cycle 5 -> busy=0 immediately and no flush_done.
